// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its two requesters plus the
// single-ported memory. The arbiter takes the slave view; the requesters and
// memory model take the master view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 16
);
    // Requester port m0 (CPU controller)
    logic                  m0_req;
    logic                  m0_we;
    logic [DATA_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_done;
    logic [DATA_WIDTH-1:0] m0_rdata;

    // Requester port m1 (loader / DMA)
    logic                  m1_req;
    logic                  m1_we;
    logic [DATA_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_done;
    logic [DATA_WIDTH-1:0] m1_rdata;

    // Memory side
    logic                  mem_addr_en;
    logic                  mem_in_en;
    logic                  mem_out_en;
    logic [DATA_WIDTH-1:0] mem_bus;
    logic                  mem_bus_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Status
    logic                  busy;

    // Arbiter view
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output mem_addr_en, mem_in_en, mem_out_en, mem_bus, mem_bus_en,
        input  mem_rdata,
        output busy
    );

    // Requester / memory view
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  mem_addr_en, mem_in_en, mem_out_en, mem_bus, mem_bus_en,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and address-then-data transfer sequencer
// for the single-ported memory on the shared bus. One transaction takes three
// cycles (ADDR, DATA, then a done cycle that is also an arbitration cycle).
// Every output is a register so the bus mux and memory enables are glitch-free.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

    // Arbitration result packed as {valid, winner}. On a tie the port that
    // did not win last time takes the grant, which guarantees alternation.
    function automatic logic [1:0] arbitrate(input logic req0,
                                             input logic req1,
                                             input logic last);
        logic [1:0] res;
        if (req0 && req1) begin
            res = {1'b1, ~last};
        end else if (req0) begin
            res = {1'b1, PORT_M0};
        end else if (req1) begin
            res = {1'b1, PORT_M1};
        end else begin
            res = {1'b0, PORT_M0};
        end
        return res;
    endfunction

    // FSM and transaction registers
    state_t                state_q;
    logic                  last_q;
    logic                  owner_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Registered outputs
    logic                  m0_gnt_q;
    logic                  m1_gnt_q;
    logic                  m0_done_q;
    logic                  m1_done_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;
    logic                  mem_addr_en_q;
    logic                  mem_in_en_q;
    logic                  mem_out_en_q;
    logic [DATA_WIDTH-1:0] mem_bus_q;
    logic                  mem_bus_en_q;
    logic                  busy_q;

    // Arbitration decision and the request fields of the would-be winner
    logic [1:0]            arb_s;
    logic                  grant_valid_d;
    logic                  grant_owner_d;
    logic                  we_d;
    logic [DATA_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    // Pick the winner for this edge and mux its request fields
    always_comb begin
        arb_s         = arbitrate(bus.m0_req, bus.m1_req, last_q);
        grant_valid_d = arb_s[1];
        grant_owner_d = arb_s[0];
        if (grant_owner_d == PORT_M1) begin
            we_d    = bus.m1_we;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
        end else begin
            we_d    = bus.m0_we;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
        end
    end

    // Transfer sequencer: IDLE -> ADDR -> DATA -> IDLE with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_q        <= PORT_M1;
            owner_q       <= PORT_M0;
            we_q          <= 1'b0;
            addr_q        <= {DATA_WIDTH{1'b0}};
            wdata_q       <= {DATA_WIDTH{1'b0}};
            m0_gnt_q      <= 1'b0;
            m1_gnt_q      <= 1'b0;
            m0_done_q     <= 1'b0;
            m1_done_q     <= 1'b0;
            m0_rdata_q    <= {DATA_WIDTH{1'b0}};
            m1_rdata_q    <= {DATA_WIDTH{1'b0}};
            mem_addr_en_q <= 1'b0;
            mem_in_en_q   <= 1'b0;
            mem_out_en_q  <= 1'b0;
            mem_bus_q     <= {DATA_WIDTH{1'b0}};
            mem_bus_en_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless DATA sets it below
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        state_q       <= ST_ADDR;
                        owner_q       <= grant_owner_d;
                        last_q        <= grant_owner_d;
                        we_q          <= we_d;
                        addr_q        <= addr_d;
                        wdata_q       <= wdata_d;
                        m0_gnt_q      <= (grant_owner_d == PORT_M0);
                        m1_gnt_q      <= (grant_owner_d == PORT_M1);
                        mem_addr_en_q <= 1'b1;
                        mem_in_en_q   <= 1'b0;
                        mem_out_en_q  <= 1'b0;
                        mem_bus_q     <= addr_d;
                        mem_bus_en_q  <= 1'b1;
                        busy_q        <= 1'b1;
                    end else begin
                        state_q       <= ST_IDLE;
                        m0_gnt_q      <= 1'b0;
                        m1_gnt_q      <= 1'b0;
                        mem_addr_en_q <= 1'b0;
                        mem_in_en_q   <= 1'b0;
                        mem_out_en_q  <= 1'b0;
                        mem_bus_q     <= {DATA_WIDTH{1'b0}};
                        mem_bus_en_q  <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    state_q       <= ST_DATA;
                    mem_addr_en_q <= 1'b0;
                    if (we_q) begin
                        mem_in_en_q  <= 1'b1;
                        mem_out_en_q <= 1'b0;
                        mem_bus_q    <= wdata_q;
                        mem_bus_en_q <= 1'b1;
                    end else begin
                        // memory drives the bus during a read
                        mem_in_en_q  <= 1'b0;
                        mem_out_en_q <= 1'b1;
                        mem_bus_q    <= {DATA_WIDTH{1'b0}};
                        mem_bus_en_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    state_q       <= ST_IDLE;
                    m0_gnt_q      <= 1'b0;
                    m1_gnt_q      <= 1'b0;
                    m0_done_q     <= (owner_q == PORT_M0);
                    m1_done_q     <= (owner_q == PORT_M1);
                    mem_addr_en_q <= 1'b0;
                    mem_in_en_q   <= 1'b0;
                    mem_out_en_q  <= 1'b0;
                    mem_bus_q     <= {DATA_WIDTH{1'b0}};
                    mem_bus_en_q  <= 1'b0;
                    busy_q        <= 1'b0;
                    if (!we_q) begin
                        if (owner_q == PORT_M1) begin
                            m1_rdata_q <= bus.mem_rdata;
                        end else begin
                            m0_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        m0_rdata_q <= m0_rdata_q;
                        m1_rdata_q <= m1_rdata_q;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    m0_gnt_q      <= 1'b0;
                    m1_gnt_q      <= 1'b0;
                    mem_addr_en_q <= 1'b0;
                    mem_in_en_q   <= 1'b0;
                    mem_out_en_q  <= 1'b0;
                    mem_bus_q     <= {DATA_WIDTH{1'b0}};
                    mem_bus_en_q  <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m0_gnt      = m0_gnt_q;
    assign bus.m1_gnt      = m1_gnt_q;
    assign bus.m0_done     = m0_done_q;
    assign bus.m1_done     = m1_done_q;
    assign bus.m0_rdata    = m0_rdata_q;
    assign bus.m1_rdata    = m1_rdata_q;
    assign bus.mem_addr_en = mem_addr_en_q;
    assign bus.mem_in_en   = mem_in_en_q;
    assign bus.mem_out_en  = mem_out_en_q;
    assign bus.mem_bus     = mem_bus_q;
    assign bus.mem_bus_en  = mem_bus_en_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed test-plan steps followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.DATA_WIDTH(DW)) arb_if ();

    mem_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb_if)
    );

    always #5 clk = ~clk;

    // Memory model: latches the address, writes on mem_in_en, reads on mem_out_en
    logic [DW-1:0] env_mem [0:65535];
    logic [DW-1:0] env_lat;
    logic          pl_en;
    logic [DW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) env_mem[pl_addr] <= pl_data;
        if (arb_if.mem_addr_en) env_lat <= arb_if.mem_bus;
        if (arb_if.mem_in_en) env_mem[env_lat] <= arb_if.mem_bus;
    end

    assign arb_if.mem_rdata = arb_if.mem_out_en ? env_mem[env_lat] : 16'hA5A5;

    // Reference model: one transaction record, outputs derived from its age
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            t_g = 0;
    bit            t_act = 1'b0;
    bit            t_owner = 1'b0;
    bit            t_we = 1'b0;
    logic [DW-1:0] t_addr = 16'h0000;
    logic [DW-1:0] t_wdata = 16'h0000;
    bit            last = 1'b1;
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] ref_mem [0:65535];

    task automatic chk1(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk16(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        t_act     = 1'b0;
        last      = 1'b1;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
    endtask

    // Advance the model across one rising edge using the inputs held there
    task automatic model_edge();
        bit r0;
        bit r1;
        bit win;
        r0 = arb_if.m0_req;
        r1 = arb_if.m1_req;
        if (rst) begin
            model_reset();
        end else if ((!t_act || (cyc - t_g) >= 3) && (r0 || r1)) begin
            win     = (r0 && r1) ? ~last : (r0 ? 1'b0 : 1'b1);
            last    = win;
            t_act   = 1'b1;
            t_g     = cyc;
            t_owner = win;
            t_we    = win ? arb_if.m1_we    : arb_if.m0_we;
            t_addr  = win ? arb_if.m1_addr  : arb_if.m0_addr;
            t_wdata = win ? arb_if.m1_wdata : arb_if.m0_wdata;
            if (t_we) ref_mem[t_addr] = t_wdata;
        end
        cyc++;
        if (!rst && t_act && (cyc - t_g) == 3 && !t_we) exp_rd[t_owner] = ref_mem[t_addr];
    endtask

    // Compare every output with what the model predicts for this cycle
    task automatic check_all();
        int d;
        bit ae, ie, oe, be, bz, dn;
        d  = t_act ? (cyc - t_g) : 99;
        ae = (d == 1);
        ie = (d == 2) && t_we;
        oe = (d == 2) && !t_we;
        be = ae || ie;
        bz = (d == 1) || (d == 2);
        dn = (d == 3);
        chk1("m0_gnt", arb_if.m0_gnt, bz && !t_owner);
        chk1("m1_gnt", arb_if.m1_gnt, bz && t_owner);
        chk1("m0_done", arb_if.m0_done, dn && !t_owner);
        chk1("m1_done", arb_if.m1_done, dn && t_owner);
        chk16("m0_rdata", arb_if.m0_rdata, exp_rd[0]);
        chk16("m1_rdata", arb_if.m1_rdata, exp_rd[1]);
        chk1("mem_addr_en", arb_if.mem_addr_en, ae);
        chk1("mem_in_en", arb_if.mem_in_en, ie);
        chk1("mem_out_en", arb_if.mem_out_en, oe);
        chk1("mem_bus_en", arb_if.mem_bus_en, be);
        chk1("busy", arb_if.busy, bz);
        if (be) chk16("mem_bus", arb_if.mem_bus, ae ? t_addr : t_wdata);
        if (rst) chk16("mem_bus_rst", arb_if.mem_bus, 16'h0000);
        chk1("en_onehot",
             ($countones({arb_if.mem_addr_en, arb_if.mem_in_en, arb_if.mem_out_en}) <= 1), 1'b1);
        chk1("en_idle",
             arb_if.busy || !(arb_if.mem_addr_en || arb_if.mem_in_en || arb_if.mem_out_en), 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reset_now();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
    endtask

    task automatic drive(bit p, bit req, bit we, logic [DW-1:0] a, logic [DW-1:0] wd);
        if (p) begin
            arb_if.m1_req = req; arb_if.m1_we = we; arb_if.m1_addr = a; arb_if.m1_wdata = wd;
        end else begin
            arb_if.m0_req = req; arb_if.m0_we = we; arb_if.m0_addr = a; arb_if.m0_wdata = wd;
        end
    endtask

    // One isolated transfer: request, three cycles, drop req in the done cycle
    task automatic xfer(bit p, bit we, logic [DW-1:0] a, logic [DW-1:0] wd);
        drive(p, 1'b1, we, a, wd);
        tick();
        tick();
        tick();
        chk1("xfer_done", p ? arb_if.m1_done : arb_if.m0_done, 1'b1);
        if (p) arb_if.m1_req = 1'b0; else arb_if.m0_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        pl_en = 1'b0; pl_addr = 16'h0000; pl_data = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;

        // Reset state, then preload memory while held in reset
        #1;
        reset_now();
        chk1("rst_busy", arb_if.busy, 1'b0);
        for (int i = 0; i < 17; i++) begin
            pl_en   = 1'b1;
            pl_addr = (i == 16) ? 16'h0040 : (16'h0300 + 16'(i));
            pl_data = (i == 16) ? 16'h1234 : 16'($urandom);
            ref_mem[pl_addr] = pl_data;
            tick();
        end
        pl_en = 1'b0;
        rst = 1'b0;
        tick();

        // Single m0 read of 0x0040
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        tick();
        chk16("rd_addr_phase", arb_if.mem_bus, 16'h0040);
        tick();
        chk1("rd_out_en", arb_if.mem_out_en, 1'b1);
        tick();
        chk1("rd_done", arb_if.m0_done, 1'b1);
        chk16("rd_1234", arb_if.m0_rdata, 16'h1234);
        chk16("m1_quiet", arb_if.m1_rdata, 16'h0000);
        arb_if.m0_req = 1'b0;
        tick();

        // Single m1 write, then m0 reads it back
        drive(1'b1, 1'b1, 1'b1, 16'h0100, 16'hBEEF);
        tick();
        chk16("wr_addr_phase", arb_if.mem_bus, 16'h0100);
        tick();
        chk16("wr_data_phase", arb_if.mem_bus, 16'hBEEF);
        tick();
        chk1("wr_done", arb_if.m1_done, 1'b1);
        arb_if.m1_req = 1'b0;
        tick();
        xfer(1'b0, 1'b0, 16'h0100, 16'h0000);
        chk16("rd_beef", arb_if.m0_rdata, 16'hBEEF);

        // Both ports requesting right after reset: m0, m1, m0, m1
        reset_now();
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 16'h0301, 16'h7E57);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("rr_gnt", (k % 2 == 0) ? arb_if.m0_gnt : arb_if.m1_gnt, 1'b1);
            tick();
            tick();
            chk1("rr_done", (k % 2 == 0) ? arb_if.m0_done : arb_if.m1_done, 1'b1);
        end
        arb_if.m0_req = 1'b0;
        arb_if.m1_req = 1'b0;
        tick();

        // Inputs change and req drops during the transfer
        drive(1'b1, 1'b1, 1'b1, 16'h0200, 16'h5555);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        tick();
        chk16("latched_wdata", arb_if.mem_bus, 16'h5555);
        tick();
        chk1("drop_done", arb_if.m1_done, 1'b1);
        tick();
        xfer(1'b0, 1'b0, 16'h0200, 16'h0000);
        chk16("latched_rd", arb_if.m0_rdata, 16'h5555);

        // Reset during DATA of an m0 read, then a fresh request
        reset_now();
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        tick();
        tick();
        reset_now();
        chk1("abort_out_en", arb_if.mem_out_en, 1'b0);
        chk16("abort_rdata", arb_if.m0_rdata, 16'h0000);
        tick();
        chk1("abort_no_done", arb_if.m0_done, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk1("fresh_done", arb_if.m0_done, 1'b1);
        chk16("fresh_rdata", arb_if.m0_rdata, 16'h1234);
        arb_if.m0_req = 1'b0;
        tick();

        // Random traffic on a small address window
        for (int n = 0; n < 400; n++) begin
            drive(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  16'h0300 + 16'($urandom_range(0, 15)), 16'($urandom));
            drive(1'b1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  16'h0300 + 16'($urandom_range(0, 15)), 16'($urandom));
            tick();
        end
        arb_if.m0_req = 1'b0;
        arb_if.m1_req = 1'b0;
        for (int n = 0; n < 4; n++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and transfer sequencer for the single-ported 16-bit memory on the shared bus. It accepts word read/write requests from the CPU controller (port m0) and a second master such as a program loader or DMA engine (port m1). It grants one requester at a time with round-robin fairness and runs the memory's address-then-data sequence on the winner's behalf. It drives the memory enables and the bus value the top level muxes onto the bus.

## Interface
- DATA_WIDTH, default 16, width of address, write data and read data.
- clk  in  1  system clock (the divided 1 MHz core clock); all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- m0_req / m1_req  in  1  level request; held high until done, or longer for back-to-back transfers.
- m0_we / m1_we  in  1  1 = write, 0 = read; sampled at grant.
- m0_addr / m1_addr  in  DATA_WIDTH  word address; sampled at grant.
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data; sampled at grant.
- m0_gnt / m1_gnt  out  1  registered; high for the whole transaction owned by that port.
- m0_done / m1_done  out  1  registered one-cycle pulse marking transaction completion.
- m0_rdata / m1_rdata  out  DATA_WIDTH  registered read data; valid from the done cycle and held until that port's next read completes.
- mem_addr_en  out  1  memory address-latch enable.
- mem_in_en  out  1  memory write enable.
- mem_out_en  out  1  memory read enable.
- mem_bus  out  DATA_WIDTH  value to place on the bus; meaningful only while mem_bus_en = 1.
- mem_bus_en  out  1  arbiter owns the bus this cycle; the top-level bus mux selects mem_bus.
- mem_rdata  in  DATA_WIDTH  memory read output; valid in the cycle mem_out_en = 1.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, ADDR, DATA. Flow is IDLE→ADDR on a grant, ADDR→DATA always, DATA→IDLE always.
- In IDLE, arbitration evaluates at each edge:
  - Neither port requesting: stay in IDLE.
  - Exactly one port requesting: grant that port.
  - Both ports requesting: grant the port that was not granted last.
- The `last` pointer updates at each grant. Reset sets last = m1, so m0 wins the first tie.
- On grant, the arbiter latches the owner, we, addr and wdata into internal registers and sets the owner's gnt.
- Later changes on the inputs have no effect on the in-flight transaction.
- ADDR state: mem_addr_en = 1, mem_bus_en = 1, mem_bus = latched addr.
- DATA state, write: mem_in_en = 1, mem_bus_en = 1, mem_bus = latched wdata.
- DATA state, read: mem_out_en = 1, mem_bus_en = 0 (the memory drives the bus). At the DATA→IDLE edge, mem_rdata is captured into the owner's rdata register.
- At the DATA→IDLE edge, the owner's done is set for one cycle and its gnt clears.
- The other port's rdata is never altered.
- Only one of mem_addr_en, mem_in_en, mem_out_en is high in any cycle. All three are 0 in IDLE.
- A requester dropping req mid-transaction has no effect: the transaction completes and done still pulses.
- Port m1 is never starved: when both ports request continuously, grants alternate m0, m1, m0, ...

## Timing
- Reset values: state IDLE, last = m1, and every output 0 (gnt, done, rdata, mem enables, mem_bus, mem_bus_en, busy).
- Asserting rst mid-transaction abandons the transfer: no done pulse, no rdata update, and the enables drop asynchronously.
- Transaction timeline, with edge k ending cycle k:
  - Req sampled high in IDLE at edge 0.
  - Cycle 1 is ADDR (gnt high).
  - Cycle 2 is DATA.
  - Cycle 3 has done high, gnt low, state IDLE.
- Latency from req sampled to done is 3 cycles. Sustained throughput is one transfer per 3 cycles.
- The IDLE cycle carrying done is also an arbitration cycle:
  - Req still high at the end of that cycle starts another transfer.
  - A requester wanting exactly one transfer deasserts req during its done cycle.
- gnt and done are never high together for the same port.

## Test plan
- Single m0 read: memory preloaded with 0x1234 at 0x0040; m0 reads 0x0040.
  - Required: mem_addr_en in cycle 1 with mem_bus = 0x0040, mem_out_en in cycle 2, m0_done in cycle 3, m0_rdata = 0x1234.
  - Required: m1 outputs stay 0.
- Single m1 write of 0xBEEF to 0x0100.
  - Required: cycle 1 mem_bus = 0x0100; cycle 2 mem_in_en = 1 with mem_bus = 0xBEEF; m1_done in cycle 3.
  - Required: a subsequent m0 read of 0x0100 returns 0xBEEF.
- Simultaneous requests right after reset, both held high for 4 transfers.
  - Required: grant order m0, m1, m0, m1, with done pulses at cycles 3, 6, 9, 12.
- Address and data changed during ADDR/DATA, and req dropped in cycle 1.
  - Required: the transfer uses the originally latched values and done still pulses.
- rst asserted during DATA of an m0 read.
  - Required: all outputs 0 immediately, no m0_done, m0_rdata unchanged at 0.
  - Required: after rst release, a fresh m0 request completes normally.
- Enable exclusivity checked throughout all tests: at most one of mem_addr_en, mem_in_en, mem_out_en is high per cycle, and all are 0 whenever busy = 0.
